// File: rtl/ysyx_22051468_div_unit.sv
`default_nettype none
// ============================================================================
// Module : ysyx_22051468_div_unit
// Brief  : RV64M multi-cycle restoring divider (DIV/DIVU/REM/REMU + W forms)
// Rev    : 1.0
// ============================================================================
module ysyx_22051468_div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] dividend,
    input  logic [63:0] divisor,
    input  logic        is_div,
    input  logic        is_rem,
    input  logic        is_U,
    input  logic        is_W,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q;
    logic [6:0]  cnt_q;
    logic [63:0] quo_q;
    logic [63:0] rem_q;
    logic [63:0] dvs_q;
    logic        q_neg_q;
    logic        r_neg_q;
    logic        rem_sel_q;
    logic        w_op_q;
    logic        out_valid_q;
    logic [63:0] result_q;

    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic        w_sa;
    logic        w_sb;
    logic [63:0] w_abs_a;
    logic [63:0] w_abs_b;
    logic        w_div0;
    logic        w_ovf;
    logic [63:0] w_quo_init;
    logic [64:0] w_shift;
    logic [64:0] w_diff;
    logic        w_ge;
    logic [63:0] w_rem_next;
    logic        w_last;
    logic [63:0] w_q_fix;
    logic [63:0] w_r_fix;
    logic [63:0] w_sel;
    logic [63:0] w_fix;
    logic        w_unused;

    // Quotient vs remainder selection is driven by is_rem alone.
    assign w_unused = is_div;

    assign w_a_ext = is_W ? (is_U ? {32'd0, dividend[31:0]} : {{32{dividend[31]}}, dividend[31:0]})
                          : dividend;
    assign w_b_ext = is_W ? (is_U ? {32'd0, divisor[31:0]}  : {{32{divisor[31]}},  divisor[31:0]})
                          : divisor;
    assign w_sa    = ~is_U & w_a_ext[63];
    assign w_sb    = ~is_U & w_b_ext[63];
    assign w_abs_a = w_sa ? (~w_a_ext + 64'd1) : w_a_ext;
    assign w_abs_b = w_sb ? (~w_b_ext + 64'd1) : w_b_ext;
    assign w_div0  = (w_b_ext == 64'd0);
    assign w_ovf   = ~is_U & (w_b_ext == {64{1'b1}}) &
                     (is_W ? (w_a_ext[31:0] == 32'h8000_0000)
                           : (w_a_ext == 64'h8000_0000_0000_0000));
    // Word ops park the 32-bit magnitude in the top half so 32 shifts consume it.
    assign w_quo_init = is_W ? {w_abs_a[31:0], 32'd0} : w_abs_a;

    assign w_shift    = {rem_q, quo_q[63]};
    assign w_diff     = w_shift - {1'b0, dvs_q};
    assign w_ge       = ~w_diff[64];
    assign w_rem_next = w_ge ? w_diff[63:0] : w_shift[63:0];
    assign w_last     = (cnt_q == (w_op_q ? 7'd31 : 7'd63));

    assign w_q_fix = q_neg_q ? (~quo_q + 64'd1) : quo_q;
    assign w_r_fix = r_neg_q ? (~rem_q + 64'd1) : rem_q;
    assign w_sel   = rem_sel_q ? w_r_fix : w_q_fix;
    assign w_fix   = w_op_q ? {{32{w_sel[31]}}, w_sel[31:0]} : w_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 7'd0;
            quo_q       <= 64'd0;
            rem_q       <= 64'd0;
            dvs_q       <= 64'd0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            rem_sel_q   <= 1'b0;
            w_op_q      <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= 64'd0;
        end else if (flush) begin
            state_q     <= S_IDLE;
            cnt_q       <= 7'd0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_q <= 7'd0;
                    if (in_valid) begin
                        rem_sel_q <= is_rem;
                        w_op_q    <= is_W;
                        dvs_q     <= w_abs_b;
                        if (w_div0) begin
                            quo_q   <= {64{1'b1}};
                            rem_q   <= w_a_ext;
                            q_neg_q <= 1'b0;
                            r_neg_q <= 1'b0;
                            state_q <= S_FIX;
                        end else if (w_ovf) begin
                            quo_q   <= w_a_ext;
                            rem_q   <= 64'd0;
                            q_neg_q <= 1'b0;
                            r_neg_q <= 1'b0;
                            state_q <= S_FIX;
                        end else begin
                            quo_q   <= w_quo_init;
                            rem_q   <= 64'd0;
                            q_neg_q <= w_sa ^ w_sb;
                            r_neg_q <= w_sa;
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    quo_q <= {quo_q[62:0], w_ge};
                    rem_q <= w_rem_next;
                    if (w_last) begin
                        cnt_q   <= 7'd0;
                        state_q <= S_FIX;
                    end else begin
                        cnt_q <= cnt_q + 7'd1;
                    end
                end
                S_FIX: begin
                    result_q    <= w_fix;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22051468_div_unit.sv
`default_nettype none
// Scoreboard bench for ysyx_22051468_div_unit: stimulus pushes expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_ysyx_22051468_div_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] dividend = 64'd0;
    logic [63:0] divisor = 64'd0;
    logic        is_div = 1'b0;
    logic        is_rem = 1'b0;
    logic        is_U = 1'b0;
    logic        is_W = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] result;
    logic        busy;

    ysyx_22051468_div_unit dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .dividend (dividend),
        .divisor  (divisor),
        .is_div   (is_div),
        .is_rem   (is_rem),
        .is_U     (is_U),
        .is_W     (is_W),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] res;
        int          lat;
        int          acc;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   op_id = 0;
    bit   seen = 1'b0;
    int   first_cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%h required=0x%h", nm, act, exp);
        end
    endtask

    // Latency = accept edge plus every edge up to the one that raises out_valid.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && !seen) begin
                seen = 1'b1;
                first_cyc = cyc;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_output: actual=0x%h required=none", result);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk($sformatf("result_op%0d", e.id), result, e.res);
                    chk($sformatf("latency_op%0d", e.id), 64'(first_cyc - e.acc + 1), 64'(e.lat));
                end
                seen = 1'b0;
            end
        end
    end

    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic d,
                         input logic r, input logic u, input logic w,
                         input logic [63:0] exp, input int lat, input bit push);
        int k;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 300) begin
            @(negedge clk);
            k++;
        end
        op_id++;
        if (!in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL in_ready_timeout_op%0d: actual=0 required=1", op_id);
        end else begin
            dividend = a; divisor = b; is_div = d; is_rem = r; is_U = u; is_W = w;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (push) sb.push_back('{res: exp, lat: lat, acc: cyc, id: op_id});
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_result"}, result, 64'd0);
    endtask

    initial begin
        int k;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // 64-bit unsigned and signed
        issue(64'd100, 64'd7, 1, 0, 1, 0, 64'd14, 66, 1);
        issue(64'd100, 64'd7, 0, 1, 1, 0, 64'd2, 66, 1);
        issue(-64'sd7, 64'd2, 1, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFD, 66, 1);
        issue(-64'sd7, 64'd2, 0, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 66, 1);
        issue(64'd7, -64'sd2, 1, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFD, 66, 1);
        issue(64'd7, -64'sd2, 0, 1, 0, 0, 64'd1, 66, 1);
        issue(64'd100, 64'd7, 1, 1, 0, 0, 64'd2, 66, 1);
        // special cases
        issue(64'd5, 64'd0, 1, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 2, 1);
        issue(64'd5, 64'd0, 0, 1, 1, 0, 64'd5, 2, 1);
        issue(64'h8000_0000_0000_0000, {64{1'b1}}, 1, 0, 0, 0, 64'h8000_0000_0000_0000, 2, 1);
        issue(64'h8000_0000_0000_0000, {64{1'b1}}, 0, 1, 0, 0, 64'd0, 2, 1);
        // word ops
        issue(64'h1234_5678_8000_0000, {64{1'b1}}, 1, 0, 0, 1, 64'hFFFF_FFFF_8000_0000, 2, 1);
        issue(64'h0000_0000_FFFF_FFFF, 64'd1, 1, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 34, 1);
        issue(64'h0000_0000_8000_0001, 64'd0, 0, 1, 0, 1, 64'hFFFF_FFFF_8000_0001, 2, 1);
        issue(64'h0000_0000_FFFF_FF9C, 64'hAAAA_0000_0000_0007, 1, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFF2, 34, 1);
        issue(64'h0000_0000_FFFF_FF9C, 64'd7, 0, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 34, 1);

        // flush mid-CALC with a simultaneous in_valid
        issue(64'd100, 64'd7, 1, 0, 1, 0, 64'd0, 0, 0);
        repeat (20) @(negedge clk);
        dividend = 64'd5; divisor = 64'd0; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        repeat (70) @(negedge clk);
        chk("flush_no_out_valid", 64'(out_valid), 64'd0);
        issue(64'd100, 64'd7, 1, 0, 1, 0, 64'd14, 66, 1);

        // asynchronous reset mid-CALC
        issue(64'd100, 64'd7, 1, 0, 1, 0, 64'd0, 0, 0);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("midcalc_reset");
        @(negedge clk);
        rst_n = 1'b1;

        // backpressure in DONE
        out_ready = 1'b0;
        issue(64'd100, 64'd7, 1, 0, 1, 0, 64'd14, 66, 1);
        k = 0;
        while (!out_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        for (int i = 0; i < 10; i++) begin
            dividend = 64'd5; divisor = 64'd0; in_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("bp_out_valid_%0d", i), 64'(out_valid), 64'd1);
            chk($sformatf("bp_result_%0d", i), result, 64'd14);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_after_hs", 64'(in_ready), 64'd1);

        k = 0;
        while (sb.size() != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL pending_results: actual=%0d required=0", sb.size());
        end
        repeat (80) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ysyx_22051468_div_unit.md
# ysyx_22051468_div_unit

Multi-cycle RV64M divide/remainder unit in the execute stage, directly downstream of the opcode decoder. It consumes the decoder's `is_div`, `is_rem`, `is_U` and `is_W` flags together with the two register operands. It computes DIV/DIVU/REM/REMU/DIVW/DIVUW/REMW/REMUW with a radix-2 restoring algorithm. Results are returned to the writeback path through a valid/ready handshake.

## Interface
- No parameters; datapath width is fixed at 64.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operands and flags valid; asserted only for div/rem instructions.
- `in_ready`  out  1  unit can accept; high only in IDLE.
- `dividend`  in  64  rs1 value.
- `divisor`  in  64  rs2 value.
- `is_div`  in  1  quotient requested (informational; selection uses `is_rem`).
- `is_rem`  in  1  1 = return remainder, 0 = return quotient.
- `is_U`  in  1  unsigned operation.
- `is_W`  in  1  32-bit word operation.
- `flush`  in  1  synchronous kill from branch/exception; aborts any operation.
- `out_valid`  out  1  `result` valid.
- `out_ready`  in  1  consumer accepts `result`.
- `result`  out  64  quotient or remainder; sign-extended from bit 31 when `is_W`.
- `busy`  out  1  state != IDLE.

## Operation
- States:
  - IDLE: wait for accept.
  - CALC: iterate the divider.
  - FIX: apply sign correction and special-case results.
  - DONE: hold the result until the consumer takes it.
- Accept occurs when `in_valid & in_ready & ~flush`. On accept, latch `is_rem`, `is_U`, `is_W` and the operands.
- Operand preparation for `is_W`: use bits [31:0] of each operand, sign-extended when `is_U=0` and zero-extended when `is_U=1`.
- For signed ops, divide magnitudes (absolute values).
  - Record `q_neg = sign(dividend) ^ sign(divisor)`.
  - Record `r_neg = sign(dividend)`.
- Iteration count N is 64 for normal ops and 32 for `is_W`. A 7-bit counter runs 0..N-1 with one quotient bit per CALC cycle.
- Special cases are detected at accept. They go IDLE→FIX directly and skip CALC.
  - Divide by zero (divisor, after W-extension, == 0): quotient = all ones; remainder = prepared dividend.
  - Signed overflow (dividend = most-negative of the operating width, divisor = -1, `is_U=0`): quotient = dividend; remainder = 0.
- FIX:
  - Negate the quotient if `q_neg` and the remainder if `r_neg` (signed only).
  - Select by `is_rem`.
  - If `is_W`, `result = {{32{r[31]}}, r[31:0]}`; this applies to the unsigned W variants as well.
- DONE: `out_valid=1`; `result` stays stable until `out_valid & out_ready`, then the unit moves to IDLE.
- Flush: in any state, next state is IDLE.
  - `out_valid` drops on the next edge.
  - The counter clears.
  - A simultaneous `in_valid` is not accepted.
- `is_div` and `is_rem` both high: remainder is returned.

## Timing
- Reset values:
  - state = IDLE, so `in_ready=1` and `busy=0`.
  - `out_valid=0`, `result=0`, counter = 0.
- Latency from the accepting edge to the first cycle with `out_valid=1`:
  - 64-bit op: 66 cycles (64 CALC + 1 FIX + DONE entry).
  - W op: 34 cycles.
  - Special case: 2 cycles.
- Throughput: one op in flight. `in_ready` returns the cycle after the output handshake, so there is no accept in the same cycle as the output handshake.
- `out_ready` low in DONE: hold the result indefinitely with no change.
- Reset asserted mid-CALC or mid-DONE: immediately return to the reset values; no result is produced.
- `result` is registered and driven from DONE only. It keeps its last value in IDLE and is don't-care when `out_valid=0`.

## Test plan
- Unsigned 64-bit:
  - 100 / 7 with `is_U=1`, `is_rem=0` → `result=14`, `out_valid` 66 cycles after accept.
  - Same operands with `is_rem=1` → `result=2`.
- Signed sign handling:
  - -7 / 2 → `0xFFFF_FFFF_FFFF_FFFD` (-3).
  - REM of the same → `0xFFFF_FFFF_FFFF_FFFF` (-1).
  - 7 / -2 → -3; REM → 1.
- Special cases:
  - DIV 5 / 0 → all ones.
  - REMU 5 / 0 → 5.
  - DIV `0x8000_0000_0000_0000` / -1 → `0x8000_0000_0000_0000`; REM → 0.
  - All three have 2-cycle latency.
- Word ops:
  - DIVW `0x1234_5678_8000_0000` / -1 → `0xFFFF_FFFF_8000_0000`.
  - DIVUW `0xFFFF_FFFF` / 1 → `0xFFFF_FFFF_FFFF_FFFF`.
  - REMW x / 0 with x = `0x0000_0000_8000_0001` → `0xFFFF_FFFF_8000_0001`.
  - Non-special W ops have 34-cycle latency.
- Flush and reset:
  - Flush at CALC cycle 20 → `busy=0` and `in_ready=1` next cycle; no `out_valid`; the next op (100/7) then completes correctly.
  - `rst_n` pulsed low mid-CALC → all outputs return to reset values immediately.
- Backpressure: hold `out_ready=0` for 10 cycles in DONE → `out_valid` stays 1 and `result` is stable; `in_valid` is ignored. Raise `out_ready` → handshake completes, then `in_ready=1` on the next cycle.
